// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine motor path.
// Holds the motor state encoding and the default duty/ramp constants that the
// cycle controller and the motor drive must agree on.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_BRAKE = 3'd4,
    ST_FAULT = 3'd5
  } motor_state_e;

  localparam logic [7:0] WASH_DUTY_DEF = 8'd96;
  localparam logic [7:0] SPIN_DUTY_DEF = 8'd240;
  localparam logic [7:0] RAMP_STEP_DEF = 8'd16;

  // Spin has priority over wash when both commands are asserted.
  function automatic logic [7:0] select_target(input logic       spin,
                                               input logic       wash,
                                               input logic [7:0] spin_duty,
                                               input logic [7:0] wash_duty);
    if (spin)      return spin_duty;
    else if (wash) return wash_duty;
    else           return 8'd0;
  endfunction

endpackage

// File: rtl/wm_pwm_gen.sv
// Free-running 8-bit PWM generator.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   duty         : compare value; 0 keeps the gate permanently low
//   pwm_out      : high while the counter is below duty
module wm_pwm_gen (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] duty,
  output logic       pwm_out
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;  // natural 8-bit wrap from 255 to 0
  end

  // NOTE: asynchronous reset lives in the sensitivity list; only control state
  // is reset here, there is no memory array that would need it avoided.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end

  // Decoded from the registered counter and the registered duty in the
  // parent, so there is no input-to-output combinational path.
  assign pwm_out = (cnt_q < duty);

endmodule

// File: rtl/wm_motor_drive.sv
// Motor drive: soft-start/soft-stop duty ramping, wash agitation with
// direction reversal, lid interlock and fault latch.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   motor_wash, motor_spin : commands from the cycle controller (spin wins)
//   lid_closed             : lid sensor, 1 = closed
//   fault_clr              : single-cycle fault acknowledge
//   pwm_out, dir, duty     : motor gate, direction (0 = forward), applied duty
//   at_speed, lid_lock     : status: in RUN / lid latch engaged
//   fault                  : high while latched in FAULT
module wm_motor_drive
  import wm_pkg::*;
#(
  parameter logic [7:0]  WASH_DUTY   = WASH_DUTY_DEF,
  parameter logic [7:0]  SPIN_DUTY   = SPIN_DUTY_DEF,
  parameter logic [7:0]  RAMP_STEP   = RAMP_STEP_DEF,
  parameter int unsigned RAMP_DIV    = 4,
  parameter int unsigned AGITATE_CYC = 64,
  parameter int unsigned PAUSE_CYC   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       motor_wash,
  input  logic       motor_spin,
  input  logic       lid_closed,
  input  logic       fault_clr,
  output logic       pwm_out,
  output logic       dir,
  output logic [7:0] duty,
  output logic       at_speed,
  output logic       lid_lock,
  output logic       fault
);

  localparam int unsigned TW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned CNT_LIM = (AGITATE_CYC > PAUSE_CYC) ? AGITATE_CYC : PAUSE_CYC;
  localparam int unsigned CW      = $clog2(CNT_LIM);

  motor_state_e  state_q, state_d;
  logic [7:0]    duty_q, duty_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_speed_q, at_speed_d;
  logic          lid_lock_q, lid_lock_d;
  logic          fault_q, fault_d;

  logic [7:0]    target;
  logic          wash_only;
  logic          tick;
  logic [8:0]    up_sum;
  logic [7:0]    up_duty;
  logic [7:0]    dn_floor;
  logic [7:0]    dn_duty;

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    target    = select_target(motor_spin, motor_wash, SPIN_DUTY, WASH_DUTY);
    wash_only = motor_wash & ~motor_spin;
    tick      = (tick_q == TW'(RAMP_DIV - 1));

    // Ramp-up computed in 9 bits so 240 + 16 cannot wrap before clamping.
    up_sum   = {1'b0, duty_q} + {1'b0, RAMP_STEP};
    up_duty  = (up_sum > {1'b0, target}) ? target : up_sum[7:0];
    dn_floor = (duty_q > RAMP_STEP) ? (duty_q - RAMP_STEP) : 8'd0;
    dn_duty  = (dn_floor < target) ? target : dn_floor;

    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;

    // Lid opening while the drum may be moving overrides everything else.
    if (state_q != ST_IDLE && state_q != ST_FAULT && !lid_closed) begin
      state_d = ST_FAULT;
      duty_d  = 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          duty_d = 8'd0;
          if (target != 8'd0 && lid_closed) begin
            state_d = ST_RAMP;
            dir_d   = 1'b0;
          end
        end
        ST_RAMP: begin
          if (duty_q == target)     state_d = ST_RUN;
          else if (target < duty_q) state_d = ST_BRAKE;
          else if (tick)            duty_d  = up_duty;
        end
        ST_RUN: begin
          if (target > duty_q)      state_d = ST_RAMP;
          else if (target < duty_q) state_d = ST_BRAKE;
          else if (wash_only && cnt_q == CW'(AGITATE_CYC - 1)) begin
            state_d = ST_PAUSE;
            duty_d  = 8'd0;
          end
        end
        ST_PAUSE: begin
          duty_d = 8'd0;
          if (target == 8'd0) state_d = ST_IDLE;
          else if (cnt_q == CW'(PAUSE_CYC - 1)) begin
            state_d = ST_RAMP;
            dir_d   = ~dir_q;
          end
        end
        ST_BRAKE: begin
          if (duty_q == target)     state_d = (target == 8'd0) ? ST_IDLE : ST_RUN;
          else if (target > duty_q) state_d = ST_RAMP;
          else if (tick)            duty_d  = dn_duty;
        end
        ST_FAULT: begin
          duty_d = 8'd0;
          if (fault_clr && target == 8'd0 && lid_closed) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = 8'd0;
        end
      endcase
    end

    // Tick and dwell counters restart on every state entry; the dwell counter
    // saturates so an indefinitely long spin RUN never wraps it.
    if (state_d != state_q) begin
      tick_d = '0;
      cnt_d  = '0;
    end else begin
      tick_d = tick ? '0 : tick_q + TW'(1);
      cnt_d  = (cnt_q == CW'(CNT_LIM - 1)) ? cnt_q : cnt_q + CW'(1);
    end

    at_speed_d = (state_d == ST_RUN);
    lid_lock_d = (state_d != ST_IDLE) && (state_d != ST_FAULT);
    fault_d    = (state_d == ST_FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      duty_q     <= 8'd0;
      dir_q      <= 1'b0;
      tick_q     <= '0;
      cnt_q      <= '0;
      at_speed_q <= 1'b0;
      lid_lock_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      tick_q     <= tick_d;
      cnt_q      <= cnt_d;
      at_speed_q <= at_speed_d;
      lid_lock_q <= lid_lock_d;
      fault_q    <= fault_d;
    end
  end

  wm_pwm_gen u_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .duty    (duty_q),
    .pwm_out (pwm_out)
  );

  assign duty     = duty_q;
  assign dir      = dir_q;
  assign at_speed = at_speed_q;
  assign lid_lock = lid_lock_q;
  assign fault    = fault_q;

endmodule
